// File: rtl/tick_stopwatch.sv
// Stopwatch that turns gen_tick's square wave into a BCD mm:ss count, with lap freeze,
// pause and a sticky 59:59 -> 00:00 overflow flag.
module tick_stopwatch #(
  parameter int unsigned TICKS_PER_INC = 1
) (
  input  logic       src_clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic       tick_enable,
  output logic       running,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       overflow
);

  localparam int unsigned PrescW = (TICKS_PER_INC > 1) ? $clog2(TICKS_PER_INC) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICKS_PER_INC - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StLap} state_e;

  state_e            state_q, state_d;
  logic              tick_q;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [3:0]        so_q, so_d, st_q, st_d, mo_q, mo_d, mt_q, mt_d;
  logic [15:0]       snap_q, snap_d;
  logic              ovf_q, ovf_d;

  logic tick_rise, counting, sec_inc;

  assign tick_rise = tick & ~tick_q;
  // Command effects land on the same edge as the tick, so counting keys off the current state.
  assign counting  = ((state_q == StRun) || (state_q == StLap)) && tick_rise && !clear;
  assign sec_inc   = counting && (presc_q == PrescMax);

  // State register
  always_ff @(posedge src_clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: clear > start_stop > lap
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StIdle;
    end else if (start_stop) begin
      unique case (state_q)
        StIdle:  state_d = StRun;
        StRun:   state_d = StPause;
        StPause: state_d = StRun;
        StLap:   state_d = StPause;
        default: state_d = StIdle;
      endcase
    end else if (lap) begin
      unique case (state_q)
        StRun:   state_d = StLap;
        StLap:   state_d = StRun;
        default: state_d = state_q;
      endcase
    end
  end

  // Output decode
  always_comb begin
    running     = (state_q == StRun) || (state_q == StLap);
    tick_enable = running;
    overflow    = ovf_q;
    if (state_q == StLap) begin
      {min_tens, min_ones, sec_tens, sec_ones} = snap_q;
    end else begin
      {min_tens, min_ones, sec_tens, sec_ones} = {mt_q, mo_q, st_q, so_q};
    end
  end

  // Datapath next-state: prescaler, BCD cascade, lap snapshot
  always_comb begin
    presc_d = presc_q;
    so_d    = so_q;
    st_d    = st_q;
    mo_d    = mo_q;
    mt_d    = mt_q;
    ovf_d   = ovf_q;
    snap_d  = snap_q;
    if (clear) begin
      presc_d = '0;
      so_d    = '0;
      st_d    = '0;
      mo_d    = '0;
      mt_d    = '0;
      ovf_d   = 1'b0;
      snap_d  = '0;
    end else begin
      if (counting) begin
        presc_d = (presc_q == PrescMax) ? '0 : presc_q + 1'b1;
      end
      if (sec_inc) begin
        if (so_q == 4'd9) begin
          so_d = '0;
          if (st_q == 4'd5) begin
            st_d = '0;
            if (mo_q == 4'd9) begin
              mo_d = '0;
              if (mt_q == 4'd5) begin
                mt_d  = '0;
                ovf_d = 1'b1;
              end else begin
                mt_d = mt_q + 4'd1;
              end
            end else begin
              mo_d = mo_q + 4'd1;
            end
          end else begin
            st_d = st_q + 4'd1;
          end
        end else begin
          so_d = so_q + 4'd1;
        end
      end
      // Snapshot holds the pre-increment value when an edge coincides with the lap pulse.
      if ((state_q == StRun) && lap && !start_stop) begin
        snap_d = {mt_q, mo_q, st_q, so_q};
      end
    end
  end

  always_ff @(posedge src_clk or negedge reset) begin
    if (!reset) begin
      tick_q  <= 1'b0;
      presc_q <= '0;
      so_q    <= '0;
      st_q    <= '0;
      mo_q    <= '0;
      mt_q    <= '0;
      ovf_q   <= 1'b0;
      snap_q  <= '0;
    end else begin
      tick_q  <= tick;
      presc_q <= presc_d;
      so_q    <= so_d;
      st_q    <= st_d;
      mo_q    <= mo_d;
      mt_q    <= mt_d;
      ovf_q   <= ovf_d;
      snap_q  <= snap_d;
    end
  end

endmodule

// File: tb/tb_tick_stopwatch.sv
// Directed bench: two stopwatches (TICKS_PER_INC 1 and 2) share stimulus; expected mm:ss
// values are written as hex BCD.
module tb_tick_stopwatch;

  logic src_clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  logic start_stop = 1'b0;
  logic lap = 1'b0;
  logic clear = 1'b0;

  logic       te1, run1, ovf1, te2, run2, ovf2;
  logic [3:0] so1, st1, mo1, mt1, so2, st2, mo2, mt2;

  int checks = 0;
  int failures = 0;

  always #5 src_clk = ~src_clk;

  tick_stopwatch #(.TICKS_PER_INC(1)) u_dut1 (
    .src_clk(src_clk), .reset(reset), .tick(tick), .start_stop(start_stop), .lap(lap),
    .clear(clear), .tick_enable(te1), .running(run1), .sec_ones(so1), .sec_tens(st1),
    .min_ones(mo1), .min_tens(mt1), .overflow(ovf1)
  );

  tick_stopwatch #(.TICKS_PER_INC(2)) u_dut2 (
    .src_clk(src_clk), .reset(reset), .tick(tick), .start_stop(start_stop), .lap(lap),
    .clear(clear), .tick_enable(te2), .running(run2), .sec_ones(so2), .sec_tens(st2),
    .min_ones(mo2), .min_tens(mt2), .overflow(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] disp1();
    return {mt1, mo1, st1, so1};
  endfunction

  function automatic logic [15:0] disp2();
    return {mt2, mo2, st2, so2};
  endfunction

  function automatic logic bcd_ok();
    return (so1 <= 4'd9) && (st1 <= 4'd5) && (mo1 <= 4'd9) && (mt1 <= 4'd5) &&
           (so2 <= 4'd9) && (st2 <= 4'd5) && (mo2 <= 4'd9) && (mt2 <= 4'd5);
  endfunction

  // One clock with the given tick level and single-cycle command pulses.
  task automatic drive(input logic t, input logic ss, input logic lp, input logic cl);
    tick = t;
    start_stop = ss;
    lap = lp;
    clear = cl;
    @(negedge src_clk);
    start_stop = 1'b0;
    lap = 1'b0;
    clear = 1'b0;
  endtask

  task automatic edges(input int n, input int half, input logic chk_bcd);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      repeat (half) @(negedge src_clk);
      tick = 1'b0;
      repeat (half) @(negedge src_clk);
      if (chk_bcd) check("bcd_legal", bcd_ok(), 1);
    end
  endtask

  task automatic expect_state(input string tag, input logic [15:0] d1, input logic [15:0] d2,
                              input logic run, input logic o1, input logic o2);
    check({tag, "_disp1"}, disp1(), d1);
    check({tag, "_disp2"}, disp2(), d2);
    check({tag, "_run"}, {run1, te1, run2, te2}, {4{run}});
    check({tag, "_ovf"}, {ovf1, ovf2}, {o1, o2});
  endtask

  initial begin
    repeat (2) @(negedge src_clk);
    expect_state("reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge src_clk);
    expect_state("idle", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Basic count, 50-cycle tick period
    drive(0, 1, 0, 0);
    check("start_run", {run1, te1}, 2'b11);
    edges(20, 25, 1'b0);
    expect_state("basic20", 16'h0020, 16'h0010, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 0, 1);
    expect_state("clear1", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Carries and wrap
    drive(0, 1, 0, 0);
    edges(9, 1, 1'b1);
    expect_state("e9", 16'h0009, 16'h0004, 1'b1, 1'b0, 1'b0);
    edges(1, 1, 1'b1);
    expect_state("e10", 16'h0010, 16'h0005, 1'b1, 1'b0, 1'b0);
    edges(49, 1, 1'b1);
    expect_state("e59", 16'h0059, 16'h0029, 1'b1, 1'b0, 1'b0);
    edges(1, 1, 1'b1);
    expect_state("e60", 16'h0100, 16'h0030, 1'b1, 1'b0, 1'b0);
    edges(540, 1, 1'b1);
    expect_state("e600", 16'h1000, 16'h0500, 1'b1, 1'b0, 1'b0);
    edges(3000, 1, 1'b1);
    expect_state("e3600", 16'h0000, 16'h3000, 1'b1, 1'b1, 1'b0);
    edges(1, 1, 1'b1);
    expect_state("e3601", 16'h0001, 16'h3000, 1'b1, 1'b1, 1'b0);
    drive(0, 0, 0, 1);
    expect_state("clear_ovf", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Lap freeze and release
    drive(0, 1, 0, 0);
    edges(10, 1, 1'b0);
    drive(0, 0, 1, 0);
    expect_state("lap_in", 16'h0010, 16'h0005, 1'b1, 1'b0, 1'b0);
    edges(6, 1, 1'b0);
    expect_state("lap_hold", 16'h0010, 16'h0005, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 1, 0);
    expect_state("lap_out", 16'h0016, 16'h0008, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 0, 1);

    // Pause keeps prescaler; resume with tick high needs a fresh rise
    drive(0, 1, 0, 0);
    edges(1, 1, 1'b0);
    drive(0, 1, 0, 0);
    expect_state("pause", 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0);
    edges(5, 1, 1'b0);
    expect_state("pause_edges", 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    repeat (3) drive(1, 0, 0, 0);
    expect_state("resume_high", 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    expect_state("resume_rise", 16'h0002, 16'h0001, 1'b1, 1'b0, 1'b0);

    // Edge coinciding with RUN->PAUSE still counts
    drive(1, 1, 0, 0);
    drive(0, 0, 0, 0);
    expect_state("edge_pause", 16'h0003, 16'h0001, 1'b0, 1'b0, 1'b0);

    // clear beats start_stop
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 1);
    expect_state("clr_ss", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // start_stop beats lap: lands in PAUSE, not LAP
    drive(0, 1, 0, 0);
    edges(2, 1, 1'b0);
    drive(0, 1, 1, 0);
    expect_state("ss_lap", 16'h0002, 16'h0001, 1'b0, 1'b0, 1'b0);

    // clear beats a coincident edge
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 0);
    drive(1, 0, 0, 1);
    drive(0, 0, 0, 0);
    expect_state("clr_edge", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Edge coinciding with RUN->LAP: snapshot is pre-increment
    drive(0, 1, 0, 0);
    edges(2, 1, 1'b0);
    drive(1, 0, 1, 0);
    drive(0, 0, 0, 0);
    expect_state("edge_lap", 16'h0002, 16'h0001, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 1, 0);
    expect_state("edge_lap_out", 16'h0003, 16'h0001, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-run, observed before the next posedge
    edges(3, 1, 1'b0);
    #2 reset = 1'b0;
    #1;
    expect_state("async_rst", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge src_clk);
    reset = 1'b1;
    @(negedge src_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_stopwatch.md
# tick_stopwatch

Consumes the `tick` square wave from `gen_tick` and accumulates elapsed time as a four-digit BCD mm:ss count. Drives `gen_tick`'s `enable` input so the tick source runs only while the stopwatch is counting. Provides start/stop, lap (display freeze) and clear controls, plus a sticky overflow flag. Sits directly downstream of `gen_tick` and upstream of the display/segment driver.

## Interface
- `TICKS_PER_INC`, 1: rising edges of `tick` per one-second increment (≥1).
- `src_clk`  in  1  system clock, same clock that drives `gen_tick`.
- `reset`  in  1  asynchronous, active-low reset.
- `tick`  in  1  square-wave tick level from `gen_tick` (synchronous to `src_clk`).
- `start_stop`  in  1  single-cycle command pulse.
- `lap`  in  1  single-cycle command pulse.
- `clear`  in  1  single-cycle command pulse.
- `tick_enable`  out  1  connect to `gen_tick.enable`; high in RUN and LAP.
- `running`  out  1  high in RUN and LAP.
- `sec_ones`  out  4  displayed seconds units, BCD 0-9.
- `sec_tens`  out  4  displayed seconds tens, BCD 0-5.
- `min_ones`  out  4  displayed minutes units, BCD 0-9.
- `min_tens`  out  4  displayed minutes tens, BCD 0-5.
- `overflow`  out  1  sticky; set on 59:59→00:00 wrap.

## Operation
- States: IDLE, RUN, PAUSE, LAP. Reset state is IDLE.
- Priority per cycle: `clear` > `start_stop` > `lap`. Lower-priority pulses in the same cycle are ignored.
- `clear`, from any state: go to IDLE. Zero live count, display, prescaler and `overflow`.
- `start_stop` transitions:
  - IDLE→RUN
  - RUN→PAUSE
  - PAUSE→RUN
  - LAP→PAUSE. The display is released to the live count on entering PAUSE.
- `lap` transitions:
  - RUN→LAP: display freezes at the current live count.
  - LAP→RUN: display follows the live count again.
  - Ignored in IDLE and PAUSE.
- Edge detect: `tick_q` registers `tick` every cycle in all states. A rising edge is `tick & ~tick_q`.
- Counting happens in RUN and LAP only. Each rising edge increments the prescaler (width `$clog2(TICKS_PER_INC)`, minimum 1).
- When the prescaler equals `TICKS_PER_INC-1` at an edge, it returns to 0 and the live count advances by one second.
- BCD carries:
  - `sec_ones` 9→0 increments `sec_tens`.
  - `sec_tens` 5→0 increments `min_ones`.
  - `min_ones` 9→0 increments `min_tens`.
  - `min_tens` 5→0 is the wrap: 59:59→00:00 and `overflow`←1.
- Counting continues after a wrap. `overflow` stays set until `clear` or `reset`.
- PAUSE retains the live count and the prescaler. Edges seen in PAUSE or IDLE are discarded.
- Displayed digits = live count, except in LAP, where they equal the frozen lap snapshot.

## Timing
- Reset (`reset`=0, asynchronous): all outputs 0, state IDLE, `tick_q`=0, prescaler 0.
- Reset deassertion is synchronised externally. The first active edge after release is a normal cycle.
- All outputs are registered or decoded directly from registers, with no combinational path from inputs.
- Count latency: a rising edge sampled at posedge k (`tick`=1, `tick_q`=0) updates digits visible after posedge k.
- Command latency: a pulse at posedge k changes state, `running` and `tick_enable` after posedge k.
- `tick_enable` falls the cycle after RUN→PAUSE. Any tick edge sampled in that same cycle is discarded.
- Resume with `tick` already high: no increment until the next genuine 0→1 transition, because `tick_q` tracked `tick` while stopped.
- Simultaneous edge and `clear`: clear wins, and the count stays 00:00.
- Simultaneous edge and RUN→PAUSE or RUN→LAP:
  - RUN→PAUSE: the edge counts.
  - RUN→LAP: the edge counts, and the lap snapshot holds the pre-increment value.
- Reset asserted mid-run clears everything immediately, independent of `src_clk`.

## Test plan
- Basic count: `TICKS_PER_INC`=2, tick period 50 cycles (100 Hz/2 Hz), reset, then `start_stop`. After 20 rising edges the display reads 00:10, with `tick_enable`=1 and `running`=1.
- Carry: `TICKS_PER_INC`=1. Expect 00:09→00:10 after the 10th edge, 00:59→01:00 after the 60th, and 10:00 after 600 edges, with every digit legal BCD throughout.
- Wrap: 3600 edges from 00:00 → display 00:00 and `overflow`=1. One more edge → 00:01 with `overflow` still 1. `clear` → 00:00, `overflow`=0, state IDLE.
- Lap: at 00:05 pulse `lap`, then 3 edges. Display holds 00:05 with `running`=1. Pulse `lap` again → display reads 00:08.
- Pause/resume with `TICKS_PER_INC`=2:
  - Pause after 1 edge: prescaler=1, then 5 edges while paused cause no change.
  - Resume while `tick` is high: no increment until the next rise.
  - The first post-resume edge produces 00:01.
- Priority and reset:
  - `clear`+`start_stop` in the same cycle while running → IDLE, display 00:00.
  - `start_stop`+`lap` in RUN → PAUSE, with no lap snapshot taken.
  - `reset` driven low mid-run between clock edges → all outputs 0 before the next posedge.
